// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage latch with stall, flush, bubble ctrl gating and saturating perf counters
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int NUM_DATA = 4,
    parameter int CTRL_W = 16,
    parameter logic [CTRL_W-1:0] CTRL_GATE_MASK = 16'h0007,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       clr_cnt,
    output logic                       out_valid,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic [CNT_W-1:0]           load_cnt,
    output logic [CNT_W-1:0]           bubble_cnt,
    output logic [CNT_W-1:0]           stall_cnt
);
    logic                       valid_q, valid_d;
    logic [CTRL_W-1:0]          ctrl_q, ctrl_d;
    logic [NUM_DATA*DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]           tag_q, tag_d;
    logic [CNT_W-1:0]           load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]           bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
    logic                       ev_load, ev_bubble, ev_stall;

    always_comb begin
        valid_d = flush ? 1'b0 : stall ? valid_q : in_valid;
        ctrl_d = flush ? '0 : stall ? ctrl_q : in_ctrl;
        tag_d = flush ? '0 : stall ? tag_q : in_tag;
        // a flushed slot keeps its stale data; only valid/ctrl/tag are cleared
        data_d = (flush || stall) ? data_q : in_data;
        ev_load = !flush && !stall && in_valid;
        ev_bubble = flush || (!stall && !in_valid);
        ev_stall = stall && !flush;
        load_cnt_d = clr_cnt ? '0 : (ev_load && load_cnt_q != '1) ? load_cnt_q + CNT_W'(1) : load_cnt_q;
        bubble_cnt_d = clr_cnt ? '0 : (ev_bubble && bubble_cnt_q != '1) ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
        stall_cnt_d = clr_cnt ? '0 : (ev_stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
            tag_q <= '0;
            load_cnt_q <= '0;
            bubble_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            tag_q <= tag_d;
            load_cnt_q <= load_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_ctrl = valid_q ? ctrl_q : (ctrl_q & ~CTRL_GATE_MASK);
    assign out_data = data_q;
    assign out_tag = tag_q;
    assign load_cnt = load_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg (CNT_W=4 to reach saturation)
module tb_pipe_stage_reg;
    logic         clk = 1'b0;
    logic         rst, in_valid, stall, flush, clr_cnt;
    logic [15:0]  in_ctrl, out_ctrl;
    logic [127:0] in_data, out_data;
    logic [7:0]   in_tag, out_tag;
    logic         out_valid;
    logic [3:0]   load_cnt, bubble_cnt, stall_cnt;
    int           checks = 0;
    int           errors = 0;

    pipe_stage_reg #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .in_tag(in_tag), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data), .out_tag(out_tag),
        .load_cnt(load_cnt), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        in_ctrl = 16'h1111; in_data = {4{32'h5555_AAAA}}; in_tag = 8'hEE;
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_data", out_data, 0);
        chk("rst_cnts", {load_cnt, bubble_cnt, stall_cnt}, 0);
        rst = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'h00A5; in_tag = 8'h31;
        in_data = {32'd4, 32'd3, 32'd2, 32'd1};
        step();
        chk("pt_valid", out_valid, 1);
        chk("pt_ctrl", out_ctrl, 16'h00A5);
        chk("pt_tag", out_tag, 8'h31);
        chk("pt_data", out_data, {32'd4, 32'd3, 32'd2, 32'd1});
        chk("pt_load_cnt", load_cnt, 1);
        stall = 1'b1; in_ctrl = 16'h1234; in_tag = 8'h42;
        in_data = {32'd8, 32'd7, 32'd6, 32'd5};
        for (int i = 0; i < 3; i++) step();
        chk("st_tag", out_tag, 8'h31);
        chk("st_ctrl", out_ctrl, 16'h00A5);
        chk("st_data", out_data, {32'd4, 32'd3, 32'd2, 32'd1});
        chk("st_stall_cnt", stall_cnt, 3);
        chk("st_load_cnt", load_cnt, 1);
        stall = 1'b0;
        step();
        chk("unst_tag", out_tag, 8'h42);
        chk("unst_ctrl", out_ctrl, 16'h1234);
        chk("unst_data", out_data, {32'd8, 32'd7, 32'd6, 32'd5});
        chk("unst_load_cnt", load_cnt, 2);
        in_ctrl = 16'h00A7; in_tag = 8'h55;
        in_data = {32'd0, 32'd0, 32'd0, 32'hDEADBEEF};
        step();
        chk("full_ctrl", out_ctrl, 16'h00A7);
        stall = 1'b1; flush = 1'b1; in_data = {4{32'h0BAD_F00D}}; in_tag = 8'h66;
        step();
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_tag", out_tag, 0);
        chk("fl_word0", out_data[31:0], 32'hDEADBEEF);
        chk("fl_bubble_cnt", bubble_cnt, 1);
        chk("fl_stall_cnt", stall_cnt, 3);
        chk("fl_load_cnt", load_cnt, 3);
        stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_ctrl = 16'hFFFF; in_tag = 8'h77;
        step();
        chk("bg_valid", out_valid, 0);
        chk("bg_ctrl", out_ctrl, 16'hFFF8);
        chk("bg_tag", out_tag, 8'h77);
        chk("bg_bubble_cnt", bubble_cnt, 2);
        in_valid = 1'b1; in_ctrl = 16'h0003;
        for (int i = 0; i < 20; i++) step();
        chk("sat_load_cnt", load_cnt, 15);
        chk("sat_bubble_cnt", bubble_cnt, 2);
        chk("sat_ctrl_ungated", out_ctrl, 16'h0003);
        clr_cnt = 1'b1; in_tag = 8'h99;
        step();
        chk("clr_cnts", {load_cnt, bubble_cnt, stall_cnt}, 0);
        chk("clr_valid", out_valid, 1);
        chk("clr_tag", out_tag, 8'h99);
        clr_cnt = 1'b0;
        step();
        chk("postclr_load_cnt", load_cnt, 1);
        stall = 1'b1;
        step();
        chk("pre_rst_stall_cnt", stall_cnt, 1);
        rst = 1'b1;
        step();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ctrl", out_ctrl, 0);
        chk("mrst_tag", out_tag, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_cnts", {load_cnt, bubble_cnt, stall_cnt}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the multi-cycle/pipelined CPU. It replaces the fixed-field stage latches (ID/EXE, EXE/MEM, MEM/WB) with one generic block. It carries a valid bit, a control bundle, N data words and an instruction tag. On top of a plain latch it adds stall (hold), flush (bubble insertion), gating of write-enable control bits on bubbles, and saturating per-stage performance counters for the debug display.

## Interface

Parameters:
- DATA_W, 32, width of one data word
- NUM_DATA, 4, number of data words carried (e.g. a, b, imm, pc4)
- CTRL_W, 16, width of the control bundle (wreg, m2reg, wmem, aluc, ...)
- CTRL_GATE_MASK, 16'h0007, ctrl bits forced to 0 on out_ctrl while out_valid=0 (write enables)
- TAG_W, 8, instruction tag width (ins_type, ins_number)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream slot holds a real instruction
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  NUM_DATA*DATA_W  upstream data words; word k is bits [k*DATA_W +: DATA_W]
- in_tag  in  TAG_W  upstream instruction tag
- stall  in  1  hold current contents
- flush  in  1  replace next contents with a bubble
- clr_cnt  in  1  synchronous clear of the performance counters
- out_valid  out  1  registered valid
- out_ctrl  out  CTRL_W  registered ctrl, with CTRL_GATE_MASK bits forced 0 when out_valid=0
- out_data  out  NUM_DATA*DATA_W  registered data words
- out_tag  out  TAG_W  registered tag
- load_cnt  out  CNT_W  valid instructions loaded
- bubble_cnt  out  CNT_W  bubbles loaded
- stall_cnt  out  CNT_W  cycles held by stall

## Operation

- Action per posedge, in priority order:
  1. rst=1: valid, ctrl, tag, data and all counters load 0.
  2. flush=1: valid←0, ctrl←0, tag←0. Data registers are not written and hold their old value. Flush wins over a simultaneous stall.
  3. stall=1: all state holds.
  4. Otherwise: load. valid←in_valid, ctrl←in_ctrl, tag←in_tag, data←in_data. In_data and in_ctrl load even when in_valid=0.
- out_ctrl = ctrl_q & ~CTRL_GATE_MASK when valid_q=0, else ctrl_q. This is the only combinational logic on the outputs. It guarantees that a bubble never writes the register file or memory, whatever garbage sits in ctrl_q.
- Counter events, evaluated only when rst=0:
  - load_cnt increments on a load (case 4) with in_valid=1.
  - bubble_cnt increments on a flush (case 2), or on a load with in_valid=0.
  - stall_cnt increments on case 3.
  - Exactly one counter event occurs per non-reset cycle.
- Counters saturate at 2^CNT_W−1 and never wrap.
- clr_cnt=1 forces all counters to 0 that cycle. It overrides any increment in the same cycle. It does not affect the pipeline contents.
- No state machine beyond the valid bit. Stage state is either EMPTY (valid=0) or FULL (valid=1), with transitions as in the priority list.

## Timing

- Latency: exactly 1 cycle from in_* to out_* when stall=0 and flush=0.
- Stall holds outputs for as many cycles as stall stays high. The first load after stall deasserts samples in_* in that cycle.
- Flush affects the outputs after the posedge on which it is sampled. It lasts one cycle per asserted cycle.
- Reset values:
  - out_valid=0, out_ctrl=0, out_tag=0, out_data=0.
  - load_cnt, bubble_cnt and stall_cnt all 0.
  - Reset takes effect on the first posedge with rst=1.
- Reset mid-stall or mid-flush: reset wins and the stage is empty on the next cycle.
- Counter outputs are registered. A count is visible the cycle after its event.

## Test plan

- Pass-through:
  - Stimulus: in_valid=1, in_ctrl=16'h00A5, in_tag=8'h31, data words 1,2,3,4, stall=flush=0.
  - Required response: the next cycle out_valid=1, out_ctrl=16'h00A5, out_tag=8'h31, words 1..4, and load_cnt=1.
- Stall hold:
  - Stimulus: after a load of tag 8'h31, assert stall for 3 cycles while in_* change.
  - Required response: outputs stay at tag 8'h31 and stall_cnt=3. Then deassert stall: the next cycle shows the current in_*.
- Flush over stall:
  - Stimulus: FULL stage with ctrl 16'h00A7, data word0=32'hDEADBEEF; assert stall=1 and flush=1 together.
  - Required response: the next cycle out_valid=0, out_ctrl=0, out_tag=0, out_data word0 still 32'hDEADBEEF, bubble_cnt=1, stall_cnt unchanged.
- Bubble gating:
  - Stimulus: load in_valid=0 with in_ctrl=16'hFFFF.
  - Required response: out_valid=0, out_ctrl=16'hFFF8 with the default mask, and bubble_cnt increments.
- Saturation and clear:
  - Stimulus: CNT_W=4, 20 consecutive valid loads.
  - Required response: load_cnt=15, no wrap. Then clr_cnt=1 with in_valid=1 and no stall or flush gives load_cnt=0 the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during a FULL, stalled stage.
  - Required response: the next cycle all outputs and all counters are 0.
